// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
// Holds default widths, the buffered entry layout and the source identifier.
// Imported by the writeback FIFO and the writeback top.
package wb_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // One buffered register write: destination and value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which producer a grant went to.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Purpose: circular buffer of DEPTH entries feeding the writeback arbiter; exposes all slots plus per-slot valid.
// Latency: an entry pushed on edge k is visible at the head after edge k (no bypass from push to head).
// Backpressure: o_full comes straight from the registered count; pushes while full and pops while empty are ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  entry_t           i_push_dat,
  input  logic             i_pop,
  output entry_t           o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output entry_t           o_entries [DEPTH],
  output logic [DEPTH-1:0] o_ent_vld
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_entries = r_mem;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: slot validity is derived from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_vld
    logic [PTR_W-1:0] w_off;
    assign w_off         = PTR_W'(gi) - r_rd_ptr;
    assign o_ent_vld[gi] = (CNT_W'(w_off) < r_count);
  end

endmodule

// File: rtl/reg_writeback.sv
// Purpose: merge ALU and load results into the register file's single write port; publish in-flight writes (WB_RR_EN: round-robin instead of mem-first).
// Latency: accepted on edge k into an empty FIFO -> we/w_addr/w_data registered after edge k+1 when granted.
// Backpressure: alu_ready/mem_ready = !full from registered count only (0 in reset); one write retired per cycle.
module reg_writeback #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 we,
  output logic [ADDR_W-1:0]    w_addr,
  output logic [DATA_W-1:0]    w_data,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic                 idle
);
  import wb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           w_alu_in, w_mem_in;
  entry_t           w_alu_head, w_mem_head, w_win;
  entry_t           w_alu_ents [DEPTH];
  entry_t           w_mem_ents [DEPTH];
  logic [DEPTH-1:0] w_alu_ent_vld, w_mem_ent_vld;
  logic             w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
  logic [CNT_W-1:0] w_alu_count, w_mem_count;
  logic             w_alu_push, w_mem_push, w_alu_pop, w_mem_pop;
  logic             w_grant_vld;
  wb_src_e          w_grant;
  logic             w_unused_ent_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_w_addr;
  logic [DATA_W-1:0] r_w_data;

  // Ready is held low in reset so nothing is accepted into a FIFO being cleared.
  assign alu_ready  = rst_n && !w_alu_full;
  assign mem_ready  = rst_n && !w_mem_full;
  assign w_alu_push = alu_valid && alu_ready;
  assign w_mem_push = mem_valid && mem_ready;
  assign w_alu_in   = '{addr: alu_addr, data: alu_data};
  assign w_mem_in   = '{addr: mem_addr, data: mem_data};

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_alu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_alu_push),
    .i_push_dat (w_alu_in),
    .i_pop      (w_alu_pop),
    .o_head     (w_alu_head),
    .o_full     (w_alu_full),
    .o_empty    (w_alu_empty),
    .o_count    (w_alu_count),
    .o_entries  (w_alu_ents),
    .o_ent_vld  (w_alu_ent_vld)
  );

  wb_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_mem_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_mem_push),
    .i_push_dat (w_mem_in),
    .i_pop      (w_mem_pop),
    .o_head     (w_mem_head),
    .o_full     (w_mem_full),
    .o_empty    (w_mem_empty),
    .o_count    (w_mem_count),
    .o_entries  (w_mem_ents),
    .o_ent_vld  (w_mem_ent_vld)
  );

`ifdef WB_RR_EN
  wb_src_e r_last;

  // Remember the most recent winner; reset to alu so mem takes the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_last <= WB_SRC_ALU;
    else if (w_grant_vld) r_last <= w_grant;
  end
`endif

  // Pick one non-empty source per cycle; contention resolved by the configured policy.
  always_comb begin
    w_grant_vld = !w_alu_empty || !w_mem_empty;
    w_grant     = WB_SRC_ALU;
    if (!w_alu_empty && !w_mem_empty) begin
`ifdef WB_RR_EN
      w_grant = (r_last == WB_SRC_ALU) ? WB_SRC_MEM : WB_SRC_ALU;
`else
      w_grant = WB_SRC_MEM;
`endif
    end else if (!w_mem_empty) begin
      w_grant = WB_SRC_MEM;
    end
  end

  assign w_alu_pop = w_grant_vld && (w_grant == WB_SRC_ALU);
  assign w_mem_pop = w_grant_vld && (w_grant == WB_SRC_MEM);
  assign w_win     = (w_grant == WB_SRC_MEM) ? w_mem_head : w_alu_head;

  // Register the granted head onto the write port; address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      r_we <= w_grant_vld;
      if (w_grant_vld) begin
        r_w_addr <= w_win.addr;
        r_w_data <= w_win.data;
      end
    end
  end

  assign we     = r_we;
  assign w_addr = r_w_addr;
  assign w_data = r_w_data;
  assign idle   = (w_alu_count == '0) && (w_mem_count == '0) && !r_we;

  // Every live buffered entry and the write currently on the port mark their register busy.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu_ent_vld[i]) pend_mask[w_alu_ents[i].addr] = 1'b1;
      if (w_mem_ent_vld[i]) pend_mask[w_mem_ents[i].addr] = 1'b1;
    end
    if (r_we) pend_mask[r_w_addr] = 1'b1;
  end

  // The mask only needs addresses; fold the snapshot data fields away.
  always_comb begin
    w_unused_ent_data = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_unused_ent_data = w_unused_ent_data ^ (^w_alu_ents[i].data) ^ (^w_mem_ents[i].data);
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
`timescale 1ns/1ps
module tb_reg_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [3:0]  alu_addr = '0, mem_addr = '0;
  logic [15:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, we, idle;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] pend_mask;

  reg_writeback #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .we(we), .w_addr(w_addr), .w_data(w_data), .pend_mask(pend_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: two queues and a write slot ----------------
  ent_t m_alu[$], m_mem[$], exp_q[$], got_q[$];
  bit         m_we;
  logic [3:0] m_waddr;
  bit         m_last_mem;
  bit         m_take_a, m_take_m, m_pick_mem;
  ent_t       m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alu.delete(); m_mem.delete(); exp_q.delete();
      m_we = 0; m_waddr = '0; m_last_mem = 0;
    end else begin
      m_take_a = alu_valid && (m_alu.size() < DEPTH);
      m_take_m = mem_valid && (m_mem.size() < DEPTH);
      if (m_alu.size() == 0 && m_mem.size() == 0) begin
        m_we = 0;
      end else begin
        if (m_alu.size() == 0)      m_pick_mem = 1;
        else if (m_mem.size() == 0) m_pick_mem = 0;
        else begin
`ifdef WB_RR_EN
          m_pick_mem = !m_last_mem;
`else
          m_pick_mem = 1;
`endif
        end
        if (m_pick_mem) m_e = m_mem.pop_front();
        else            m_e = m_alu.pop_front();
        m_last_mem = m_pick_mem;
        exp_q.push_back(m_e);
        m_we = 1;
        m_waddr = m_e.a;
      end
      if (m_take_a) m_alu.push_back({alu_addr, alu_data});
      if (m_take_m) m_mem.push_back({mem_addr, mem_data});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [15:0] mon_ep;
  ent_t        mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ep = '0;
      foreach (m_alu[i]) mon_ep[m_alu[i].a] = 1'b1;
      foreach (m_mem[i]) mon_ep[m_mem[i].a] = 1'b1;
      if (m_we) mon_ep[m_waddr] = 1'b1;
      check("we", we, m_we);
      if (we) begin
        got_q.push_back({w_addr, w_data});
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_write: got addr %0h data %0h, required no write", w_addr, w_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("w_addr", w_addr, mon_e.a);
          check("w_data", w_data, mon_e.d);
        end
      end
      check("pend_mask", pend_mask, mon_ep);
      check("idle", idle, (m_alu.size() == 0 && m_mem.size() == 0 && !m_we));
      check("alu_ready", alu_ready, (m_alu.size() < DEPTH));
      check("mem_ready", mem_ready, (m_mem.size() < DEPTH));
    end
  end

  // ---------------- driver ----------------
  ent_t aq[$], mq[$];
  bit   acc_a = 0, acc_m = 0;

  task automatic run_cycles(input int n, input int a_pct, input int m_pct);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (acc_a) begin aq.delete(0); alu_valid = 0; end
      if (acc_m) begin mq.delete(0); mem_valid = 0; end
      if (!alu_valid && aq.size() > 0 && $urandom_range(99) < a_pct) begin
        alu_valid = 1; alu_addr = aq[0].a; alu_data = aq[0].d;
      end
      if (!mem_valid && mq.size() > 0 && $urandom_range(99) < m_pct) begin
        mem_valid = 1; mem_addr = mq[0].a; mem_data = mq[0].d;
      end
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [19:0] exp);
    logic [19:0] v;
    v = (idx < got_q.size()) ? got_q[idx] : 20'hxxxxx;
    check(name, v, exp);
  endtask

  logic [3:0] ord [4];

  initial begin
    // reset state while held
    repeat (2) @(negedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_idle", idle, 1);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    #1 rst_n = 1;
    run_cycles(2, 0, 0);

    // single write latency
    aq.push_back({4'd3, 16'hBEEF});
    run_cycles(1, 100, 0);
    @(posedge clk); #1;
    check("single_pend3_e0", pend_mask[3], 1);
    check("single_we_e0", we, 0);
    run_cycles(1, 0, 0);
    @(posedge clk); #1;
    check("single_we_e1", we, 1);
    check("single_addr_e1", w_addr, 3);
    check("single_data_e1", w_data, 16'hBEEF);
    run_cycles(1, 0, 0);
    @(posedge clk); #1;
    check("single_idle_e2", idle, 1);

    // contention, twice back to back
    run_cycles(2, 0, 0);
    got_q.delete();
    aq.push_back({4'd5, 16'h0001}); aq.push_back({4'd7, 16'h0003});
    mq.push_back({4'd6, 16'h0002}); mq.push_back({4'd8, 16'h0004});
    run_cycles(8, 100, 100);
`ifdef WB_RR_EN
    ord = '{4'd6, 4'd5, 4'd8, 4'd7};
`else
    ord = '{4'd6, 4'd8, 4'd5, 4'd7};
`endif
    check("contention_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check("contention_order", (i < got_q.size()) ? got_q[i].a : 4'hx, ord[i]);

    // mem backpressure, addresses 1..4 held until accepted
    got_q.delete();
    for (int i = 1; i <= 4; i++) mq.push_back({4'(i), 16'(16'h1000 + i)});
    run_cycles(10, 0, 100);
    check("bp_count", got_q.size(), 4);
    for (int i = 1; i <= 4; i++) check_got("bp_order", i - 1, {4'(i), 16'(16'h1000 + i)});

    // steady ALU stream, one per cycle
    got_q.delete();
    for (int i = 0; i < 16; i++) aq.push_back({4'(i), 16'(i)});
    run_cycles(22, 100, 0);
    check("stream_count", got_q.size(), 16);
    for (int i = 0; i < 16; i++) check_got("stream_order", i, {4'(i), 16'(i)});

    // one alu entry against continuous mem traffic
    got_q.delete();
    for (int i = 0; i < 12; i++) mq.push_back({4'($urandom_range(15)), 16'(i)});
    aq.push_back({4'd9, 16'hA1A1});
    run_cycles(20, 100, 100);
    check("starve_count", got_q.size(), 13);
`ifdef WB_RR_EN
    check_got("rr_alu_slot", 1, {4'd9, 16'hA1A1});
`else
    check_got("starve_alu_last", 12, {4'd9, 16'hA1A1});
`endif

    // reset mid-stream with ALU entries stuck behind mem traffic
    for (int i = 0; i < 4; i++) aq.push_back({4'(i + 10), 16'(16'hC000 + i)});
    for (int i = 0; i < 6; i++) mq.push_back({4'(i), 16'(16'hD000 + i)});
    run_cycles(3, 100, 100);
    #2 rst_n = 0;
    #1;
    check("midrst_we", we, 0);
    check("midrst_pend", pend_mask, 0);
    check("midrst_idle", idle, 1);
    check("midrst_alu_ready", alu_ready, 0);
    alu_valid = 0; mem_valid = 0; acc_a = 0; acc_m = 0;
    aq.delete(); mq.delete();
    @(negedge clk);
    #2 rst_n = 1;
    run_cycles(4, 0, 0);
    check("postrst_alu_ready", alu_ready, 1);
    check("postrst_we", we, 0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      aq.push_back({4'($urandom_range(15)), 16'($urandom)});
      mq.push_back({4'($urandom_range(15)), 16'($urandom)});
    end
    run_cycles(400, 60, 50);
    for (int c = 0; c < 400 && (aq.size() > 0 || mq.size() > 0); c++) run_cycles(1, 100, 100);
    check("drain_stim_left", aq.size() + mq.size(), 0);
    run_cycles(5, 0, 0);
    check("drain_exp_left", exp_q.size(), 0);
    check("final_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
